// File: rtl/pcie_arb_pkg.sv
// Shared definitions for the C2H stream arbiter.
//   arb_state_t : arbiter FSM states
//   MAX_PORTS   : largest requester count the round-robin helper handles
//   IDX_W       : internal width of port indices (covers MAX_PORTS)
//   KEEP_W      : tkeep width for the default 256-bit XDMA stream
//   rr_first()  : first set request found scanning from a pointer, modulo n
package pcie_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS      = 8;
    localparam int IDX_W          = 3;
    localparam int C2H_DATA_WIDTH = 256;
    localparam int KEEP_W         = C2H_DATA_WIDTH / 8;

    // Scans ptr, ptr+1, ... wrapping at n. Returns 0 when nothing is set;
    // callers only use the result when at least one request is present.
    function automatic logic [IDX_W-1:0] rr_first(
        input logic [MAX_PORTS-1:0] req,
        input logic [IDX_W-1:0]     ptr,
        input int                   n
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                idx = IDX_W'((int'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice.
// Entry 0 drives the output; entry 1 holds a beat that arrived while the
// output was stalled. in_ready is a flop, so out_ready never reaches it
// combinationally. One cycle from input accept to out_valid; full rate when
// out_ready stays high.
// Ports:
//   axi_aclk, axi_aresetn            clock, synchronous active-low reset
//   in_valid/in_ready/in_*           upstream beat (data, keep, last, user)
//   out_valid/out_ready/out_*        downstream beat
module axis_skid_buffer
    import pcie_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 2
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_keep,
    input  logic                    in_last,
    input  logic [USER_WIDTH-1:0]   in_user,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_keep,
    output logic                    out_last,
    output logic [USER_WIDTH-1:0]   out_user
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + KW + 1 + USER_WIDTH;

    logic [BW-1:0] ent0_q;
    logic [BW-1:0] ent1_q;
    logic [BW-1:0] in_beat;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          in_ready_q;
    logic          push;
    logic          pop;

    assign in_beat   = {in_data, in_keep, in_last, in_user};
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt_q != 2'd0);
    assign in_ready  = in_ready_q;
    assign {out_data, out_keep, out_last, out_user} = ent0_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= in_beat;
                    else               ent1_q <= in_beat;
                end
                2'b01: ent0_q <= ent1_q;
                2'b11: begin
                    // Pop and push together: the queue shifts by one slot.
                    if (cnt_q == 2'd1) begin
                        ent0_q <= in_beat;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= in_beat;
                    end
                end
                default: ;
            endcase
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/pcie_c2h_arbiter.sv
// Packet-level round-robin arbiter sharing the XDMA C2H AXI-Stream between
// NUM_PORTS requesters. A grant lasts a whole packet; the source index rides
// on m_axis_tuser. New grants wait for user_lnk_up; a packet in flight
// always completes.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant; all s_axis_tready low; pick next requester
//   XFER  | grant_id owns the stream until its tlast beat is accepted
//
// Ports:
//   axi_aclk, axi_aresetn    stream clock, synchronous active-low reset
//   user_lnk_up              PCIe link up, gates new grants
//   s_axis_*                 flattened per-requester streams
//   m_axis_*                 merged stream to S_AXIS_C2H, tuser = source
//   busy, grant_id, pkt_cnt  status: grant held, current/last grant,
//                            packets delivered at the output
module pcie_c2h_arbiter
    import pcie_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 2
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              user_lnk_up,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    output logic [NUM_PORTS-1:0]              s_axis_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tuser,
    output logic                              busy,
    output logic [ID_WIDTH-1:0]               grant_id,
    output logic [31:0]                       pkt_cnt
);

    localparam int KW = DATA_WIDTH / 8;

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  grant_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    logic [31:0]       pkt_cnt_q;
    logic [MAX_PORTS-1:0] req_vec;

    logic              sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KW-1:0]     sel_keep;
    logic              sel_last;
    logic              skid_in_valid;
    logic              skid_in_ready;
    logic              skid_accept;

    assign req_vec = MAX_PORTS'(s_axis_tvalid);

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KW +: KW];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign skid_in_valid = (state_q == XFER) && sel_valid;
    assign skid_accept   = skid_in_valid && skid_in_ready;

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_axis_tready[i] = (state_q == XFER) && (grant_q == IDX_W'(i)) && skid_in_ready;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (user_lnk_up && (|s_axis_tvalid)) begin
                    grant_d = rr_first(req_vec, rr_ptr_q, NUM_PORTS);
                    state_d = XFER;
                end
            end
            XFER: begin
                if (skid_accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (ID_WIDTH)
    ) u_skid (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .in_valid    (skid_in_valid),
        .in_ready    (skid_in_ready),
        .in_data     (sel_data),
        .in_keep     (sel_keep),
        .in_last     (sel_last),
        .in_user     (ID_WIDTH'(grant_q)),
        .out_valid   (m_axis_tvalid),
        .out_ready   (m_axis_tready),
        .out_data    (m_axis_tdata),
        .out_keep    (m_axis_tkeep),
        .out_last    (m_axis_tlast),
        .out_user    (m_axis_tuser)
    );

    assign busy     = (state_q == XFER);
    assign grant_id = ID_WIDTH'(grant_q);
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_pcie_c2h_arbiter.sv
// Directed bench for pcie_c2h_arbiter: per-port beat queues act as the
// requesters, output beats are logged with their cycle number and compared
// against hand-computed sequences.
module tb_pcie_c2h_arbiter;
    import pcie_arb_pkg::*;

    localparam int NP = 4;
    localparam int DW = 256;
    localparam int IW = 2;
    localparam int KW = KEEP_W;

    logic               axi_aclk;
    logic               axi_aresetn;
    logic               user_lnk_up;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP-1:0]      s_axis_tready;
    logic [NP*DW-1:0]   s_axis_tdata;
    logic [NP*KW-1:0]   s_axis_tkeep;
    logic [NP-1:0]      s_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tlast;
    logic [IW-1:0]      m_axis_tuser;
    logic               busy;
    logic [IW-1:0]      grant_id;
    logic [31:0]        pkt_cnt;

    pcie_c2h_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .user_lnk_up   (user_lnk_up),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .grant_id      (grant_id),
        .pkt_cnt       (pkt_cnt)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] k;
        logic        l;
        logic [1:0]  u;
        int          cyc;
    } obeat_t;

    logic [16:0] src_q [NP][$];
    obeat_t      out_q [$];
    int          acc_cnt [NP];
    int          cyc;
    int          n_chk;
    int          n_fail;
    int          rdy_mode;
    logic [3:0]  rdy_pat;
    logic        stall_prev;
    logic        stall_pend;
    logic [15:0] stall_d;
    logic        stall_l;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        logic [16:0] b;
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                s_axis_tvalid[i]           = 1'b1;
                s_axis_tdata[i*DW +: DW]   = DW'(b[15:0]);
                s_axis_tkeep[i*KW +: KW]   = {b[15:0], ~b[15:0]};
                s_axis_tlast[i]            = b[16];
            end else begin
                s_axis_tvalid[i]           = 1'b0;
                s_axis_tdata[i*DW +: DW]   = '0;
                s_axis_tkeep[i*KW +: KW]   = '0;
                s_axis_tlast[i]            = 1'b0;
            end
        end
        m_axis_tready = (rdy_mode != 0) ? rdy_pat[2'(cyc % 4)] : 1'b1;
    endtask

    // Samples just before the rising edge, then applies the handshakes.
    task automatic tick();
        logic [NP-1:0] acc;
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back('{d: m_axis_tdata[15:0], k: m_axis_tkeep[31:16],
                              l: m_axis_tlast, u: m_axis_tuser, cyc: cyc});
        end
        if (stall_prev) begin
            chk("stall_valid_hold", 64'(m_axis_tvalid), 64'd1);
            chk("stall_data_hold", 64'(m_axis_tdata[15:0]), 64'(stall_d));
            chk("stall_last_hold", 64'(m_axis_tlast), 64'(stall_l));
            if (stall_pend && m_axis_tvalid && !m_axis_tready)
                chk("s_ready_fall", 64'(s_axis_tready[1]), 64'd0);
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        stall_pend = s_axis_tvalid[1];
        stall_d    = m_axis_tdata[15:0];
        stall_l    = m_axis_tlast;
        acc = s_axis_tvalid & s_axis_tready;
        @(posedge axi_aclk);
        cyc++;
        #1;
        for (int i = 0; i < NP; i++) begin
            if (acc[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic add_pkt(input int port, input logic [15:0] base, input int nb);
        for (int j = 0; j < nb; j++) begin
            src_q[port].push_back({(j == nb - 1), 16'(base + 16'(j))});
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NP; i++) begin
            src_q[i].delete();
            acc_cnt[i] = 0;
        end
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (out_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk(tag, 64'(out_q.size()), 64'(n));
    endtask

    task automatic do_reset();
        axi_aresetn = 1'b0;
        clear_src();
        stall_prev = 1'b0;
        drive();
        repeat (2) tick();
        axi_aresetn = 1'b1;
        tick();
        out_q.delete();
    endtask

    initial begin
        int c0;
        int bad;
        int p;
        int n;
        int t;
        n_chk = 0; n_fail = 0; cyc = 0;
        rdy_mode = 0; rdy_pat = 4'b1001;
        stall_prev = 1'b0; stall_pend = 1'b0; stall_d = '0; stall_l = 1'b0;
        axi_aresetn = 1'b0; user_lnk_up = 1'b0;
        s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
        m_axis_tready = 1'b0;
        clear_src();
        drive();
        repeat (3) tick();

        // Reset state
        chk("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_data",  64'(m_axis_tdata[63:0]), 64'd0);
        chk("rst_m_last",  64'(m_axis_tlast), 64'd0);
        chk("rst_m_user",  64'(m_axis_tuser), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_grant",   64'(grant_id), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_s_ready", 64'(s_axis_tready), 64'd0);
        axi_aresetn = 1'b1;
        tick();
        out_q.delete();

        // Single 3-beat packet from port 2
        user_lnk_up = 1'b1;
        add_pkt(2, 16'h00A0, 3);
        drive();
        c0 = cyc;
        wait_out("single_beats", 3, 20);
        for (int j = 0; j < out_q.size() && j < 3; j++) begin
            chk("single_data", 64'(out_q[j].d), 64'(16'h00A0 + 16'(j)));
            chk("single_keep", 64'(out_q[j].k), 64'(16'h00A0 + 16'(j)));
            chk("single_user", 64'(out_q[j].u), 64'd2);
            chk("single_last", 64'(out_q[j].l), 64'(j == 2));
            if (j == 0) chk("single_latency", 64'(out_q[0].cyc - c0), 64'd2);
            else        chk("single_contig", 64'(out_q[j].cyc - out_q[j-1].cyc), 64'd1);
        end
        tick();
        chk("single_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("single_busy", 64'(busy), 64'd0);

        // Fairness: every port holds two 2-beat packets
        do_reset();
        user_lnk_up = 1'b1;
        for (int q = 0; q < NP; q++) begin
            add_pkt(q, 16'(q << 8), 2);
            add_pkt(q, 16'((q << 8) | 2), 2);
        end
        drive();
        wait_out("rr_beats", 16, 200);
        for (int k = 0; k < out_q.size() && k < 16; k++) begin
            p = (k / 2) % 4;
            n = (k / 8) * 2 + (k % 2);
            chk("rr_user", 64'(out_q[k].u), 64'(p));
            chk("rr_data", 64'(out_q[k].d), 64'((p << 8) | n));
            chk("rr_last", 64'(out_q[k].l), 64'(k % 2));
            if (k > 0) chk("rr_gap", 64'(out_q[k].cyc - out_q[k-1].cyc), 64'((k % 2 == 1) ? 1 : 2));
        end
        tick();
        chk("rr_pkt_cnt", 64'(pkt_cnt), 64'd8);

        // Backpressure: 8-beat packet from port 1, m_axis_tready 1,0,0,1...
        out_q.delete();
        rdy_mode = 1;
        add_pkt(1, 16'h0100, 8);
        drive();
        wait_out("bp_beats", 8, 100);
        for (int k = 0; k < out_q.size() && k < 8; k++) begin
            chk("bp_data", 64'(out_q[k].d), 64'(16'h0100 + 16'(k)));
            chk("bp_user", 64'(out_q[k].u), 64'd1);
            chk("bp_last", 64'(out_q[k].l), 64'(k == 7));
        end
        rdy_mode = 0;
        drive();
        tick();
        stall_prev = 1'b0;
        chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd9);

        // Link gating
        out_q.delete();
        user_lnk_up = 1'b0;
        add_pkt(0, 16'h0C00, 4);
        drive();
        bad = 0;
        repeat (20) begin
            tick();
            if (s_axis_tready != '0 || m_axis_tvalid) bad++;
        end
        chk("link_gate", 64'(bad), 64'd0);
        user_lnk_up = 1'b1;
        tick();
        chk("link_grant_busy", 64'(busy), 64'd1);
        chk("link_grant_id", 64'(grant_id), 64'd0);
        tick();
        user_lnk_up = 1'b0;
        add_pkt(3, 16'h0D00, 2);
        drive();
        wait_out("link_drop_beats", 4, 40);
        for (int k = 0; k < out_q.size() && k < 4; k++) begin
            chk("link_drop_data", 64'(out_q[k].d), 64'(16'h0C00 + 16'(k)));
            chk("link_drop_last", 64'(out_q[k].l), 64'(k == 3));
        end
        bad = 0;
        repeat (15) begin
            tick();
            if (busy) bad++;
        end
        chk("link_no_regrant", 64'(bad), 64'd0);
        chk("link_no_extra", 64'(out_q.size()), 64'd4);
        chk("link_pkt_cnt", 64'(pkt_cnt), 64'd10);

        // Reset in the middle of a 6-beat packet
        clear_src();
        out_q.delete();
        user_lnk_up = 1'b1;
        add_pkt(2, 16'h0E00, 6);
        drive();
        t = 0;
        while (acc_cnt[2] < 2 && t < 30) begin
            tick();
            t++;
        end
        chk("mid_reach_beat3", 64'(acc_cnt[2]), 64'd2);
        chk("mid_busy_before", 64'(busy), 64'd1);
        axi_aresetn = 1'b0;
        clear_src();
        drive();
        tick();
        chk("mid_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_rst_busy",    64'(busy), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mid_rst_s_ready", 64'(s_axis_tready), 64'd0);
        axi_aresetn = 1'b1;
        tick();
        out_q.delete();

        // Counter wrap
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        chk("wrap_preload", 64'(pkt_cnt), 64'hFFFF_FFFF);
        add_pkt(1, 16'h0F00, 1);
        drive();
        wait_out("wrap_beat", 1, 20);
        if (out_q.size() > 0) chk("wrap_data", 64'(out_q[0].d), 64'h0F00);
        tick();
        chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_c2h_arbiter.md
Name: pcie_c2h_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single XDMA C2H AXI-Stream (256-bit, axi_aclk domain) between NUM_PORTS on-chip requesters, e.g. LegoFPGA application and a DDR4 debug/readback engine.
- Sits between the requesters and the pcie S_AXIS_C2H port. A grant is held for a whole packet. The source index is tagged on m_axis_tuser.
- New packets are gated on user_lnk_up.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- DATA_WIDTH, 256, tdata width per port; tkeep is DATA_WIDTH/8
- ID_WIDTH, 2, width of source index; must be >= clog2(NUM_PORTS)

Ports:
- axi_aclk  in  1  stream clock (XDMA axi_aclk, 250 MHz)
- axi_aresetn  in  1  synchronous active-low reset
- user_lnk_up  in  1  PCIe link up; gates new grants only
- s_axis_tvalid  in  NUM_PORTS  per-requester valid
- s_axis_tready  out  NUM_PORTS  per-requester ready
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  flattened data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  flattened keep
- s_axis_tlast  in  NUM_PORTS  end of packet
- m_axis_tvalid  out  1  to S_AXIS_C2H
- m_axis_tready  in  1  from S_AXIS_C2H
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  DATA_WIDTH/8  output keep
- m_axis_tlast  out  1  end of packet
- m_axis_tuser  out  ID_WIDTH  source port index of the current beat
- busy  out  1  grant held (state XFER)
- grant_id  out  ID_WIDTH  current/last granted port
- pkt_cnt  out  32  packets forwarded (counted at output tlast handshake), wraps at 2^32

Behaviour:
- Reset (axi_aresetn=0 at a rising edge):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0, pkt_cnt=0.
  - Skid buffer empties: m_axis_tvalid=0; tdata/tkeep/tlast/tuser=0.
  - s_axis_tready=0 on all ports.
- FSM, state IDLE:
  - All s_axis_tready=0.
  - If user_lnk_up=1 and any s_axis_tvalid: pick the first valid port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - Register grant_id = that port; go to XFER next cycle.
- FSM, state XFER:
  - s_axis_tready[grant_id] = skid input ready; all other ports 0.
  - Beat accepted when s_axis_tvalid[g] & s_axis_tready[g].
  - On an accepted beat with tlast=1: go to IDLE and set rr_ptr = (grant_id+1) mod NUM_PORTS.
  - This gives a fixed one-cycle arbitration bubble between packets.
- Link-down rules:
  - user_lnk_up falling during XFER does not abort. The packet completes; no new grant until user_lnk_up=1.
  - Non-granted tvalid may assert or drop freely in IDLE; no grant is issued on a tvalid that drops before the decision cycle.
  - Once granted, AXIS rules apply to the requester. The arbiter never drops or reorders beats.
- Output skid buffer (2 entries):
  - Latency is 1 cycle, input accept to m_axis_tvalid.
  - Full throughput when m_axis_tready is continuously high.
  - Input ready = fewer than 2 entries, registered (no combinational path from m_axis_tready to s_axis_tready).
  - tuser for each stored beat = grant_id at accept time.
- Simultaneous accept and pop: occupancy unchanged.
- m_axis_* remain stable while m_axis_tvalid=1 and m_axis_tready=0.
- pkt_cnt increments on m_axis_tvalid & m_axis_tready & m_axis_tlast; wraps 0xFFFFFFFF -> 0.
- busy = (state==XFER).
- Reset mid-packet: all state is cleared the next cycle and buffered beats are discarded. The requester is reset by the same axi_aresetn.

Decomposition:
- Shared package pcie_arb_pkg:
  - state enum {IDLE, XFER}
  - localparam KEEP_W = DATA_WIDTH/8
  - a function for round-robin first-set-from-pointer
- One sub-module, axis_skid_buffer: 2-entry register slice with parameters DATA_WIDTH and USER_WIDTH. Reusable on the H2C side.

Test Plan:
- Single packet: reset, user_lnk_up=1, port 2 sends 3 beats (tdata 0xA0,0xA1,0xA2, last on beat 3), m_axis_tready=1 -> first m_axis beat 2 cycles after tvalid rises. Beats contiguous, m_axis_tuser=2, pkt_cnt=1, busy back to 0.
- Fairness: all 4 ports hold 2-beat packets continuously from rr_ptr=0 -> output order 0,1,2,3,0,1... Exactly one idle output cycle between packets; no interleaving within a packet.
- Backpressure: m_axis_tready toggles 1,0,0,1 during an 8-beat packet from port 1 -> all 8 beats arrive in order, unchanged while stalled, tlast on beat 8 only. s_axis_tready[1] falls within 2 cycles of output stall.
- Link gating: user_lnk_up=0 with port 0 valid -> s_axis_tready=0 and m_axis_tvalid=0 for 20 cycles. Raising link -> grant within 1 cycle. Dropping link on beat 2 of 4 -> all 4 beats still delivered, then no new grant.
- Reset mid-packet: axi_aresetn=0 for 1 cycle during beat 3 of 6 -> next cycle m_axis_tvalid=0, busy=0, pkt_cnt=0, all s_axis_tready=0.
- Counter wrap: preload pkt_cnt to 0xFFFFFFFF via force, send 1 packet -> pkt_cnt=0.
